// File: rtl/simple_restoring_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, valid/ready handshake on both sides.
module simple_restoring_div #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           dz
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    prem;      // partial remainder, always < divisor
  logic [N-1:0]    bq;        // divisor captured at the input handshake
  logic [2*N-1:0]  sh;        // dividend bits shift out the top, quotient bits in the bottom
  logic [N:0]      trial;
  logic [N:0]      diff;
  logic            ge;
  logic [N-1:0]    prem_nxt;
  logic            in_hs;

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    trial    = {prem, sh[2*N-1]};
    ge       = (trial >= {1'b0, bq});
    diff     = trial - {1'b0, bq};
    prem_nxt = ge ? diff[N-1:0] : trial[N-1:0];
  end

  // Input handshake qualifier
  always_comb in_hs = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; divide-by-zero skips CALC entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = (b == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, iteration, result registers (held until next result)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      prem <= '0;
      bq   <= '0;
      sh   <= '0;
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_hs) begin
          bq   <= b;
          sh   <= a;
          prem <= '0;
          cnt  <= CW'(2*N-1);
          if (b == '0) begin
            q  <= '1;
            r  <= a[N-1:0];
            dz <= 1'b1;
          end
        end
        CALC: begin
          prem <= prem_nxt;
          sh   <= {sh[2*N-2:0], ge};
          if (cnt == '0) begin
            q  <= {sh[2*N-2:0], ge};
            r  <= prem_nxt;
            dz <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_restoring_div.sv
// Directed + random bench for simple_restoring_div (N=8).
module tb_simple_restoring_div;

  localparam int N     = 8;
  localparam int NRAND = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           dz;

  int checks = 0;
  int errors = 0;

  simple_restoring_div #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, check result latency (edge index from handshake edge 0),
  // optionally stall the output for `hold` cycles, then drain and check readiness.
  task automatic run(input string tag, input logic [15:0] ta, input logic [7:0] tbv,
                     input logic [15:0] eq, input logic [7:0] er, input logic edz,
                     input int eedge, input int hold);
    int lat;
    logic [15:0] q0;
    logic [7:0]  r0;
    logic        dz0;
    chk({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 8'h5A;          // must not affect the running division
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (hold > 0) out_ready = 1'b0;
    chk({tag, "_edge"}, 32'(lat + 1), 32'(eedge));
    chk({tag, "_q"},  32'(q),  32'(eq));
    chk({tag, "_r"},  32'(r),  32'(er));
    chk({tag, "_dz"}, 32'(dz), 32'(edz));
    q0 = q; r0 = r; dz0 = dz;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;                // ignored in DONE
      tick();
      chk({tag, "_hold"}, {6'd0, out_valid, in_ready, q, r, dz},
                          {6'd0, 1'b1, 1'b0, q0, r0, dz0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({tag, "_drain"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk({tag, "_keep"}, {7'd0, q, r, dz}, {7'd0, q0, r0, dz0});
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          w;
    logic        bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_state", {7'd0, in_ready, out_valid, q, r, dz}, {7'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    // out_ready in IDLE has no effect
    out_ready = 1'b1;
    tick();
    chk("idle_out_ready", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

    run("d1000_7",  16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17, 0);
    run("dffff_1",  16'hFFFF,  8'h01,  16'hFFFF,  8'h00,  1'b0, 17, 0);
    run("d5_ff",    16'h0005,  8'hFF,  16'h0000,  8'h05,  1'b0, 17, 0);
    run("dffff_ff", 16'hFFFF,  8'hFF,  16'h0101,  8'h00,  1'b0, 17, 0);
    run("dz1234",   16'h1234,  8'h00,  16'hFFFF,  8'h34,  1'b1, 1,  0);
    run("hold100",  16'd100,   8'd10,  16'd10,    8'd0,   1'b0, 17, 5);
    run("dz_hold",  16'h00AB,  8'h00,  16'hFFFF,  8'hAB,  1'b1, 1,  2);

    // Reset during CALC aborts; outputs take reset values immediately
    run("pre_rst",  16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17, 0);
    a = 16'd1000; b = 8'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("rst_calc", {7'd0, in_ready, out_valid, q, r, dz}, {7'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    run("d200_9",   16'd200,   8'd9,   16'd22,    8'd2,   1'b0, 17, 0);

    // Random back-to-back divisions with random output stalls
    bad = 1'b0;
    for (int i = 0; i < NRAND && !bad; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      a = ra; b = rb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 100) begin
        out_ready = 1'($urandom);     // ignored during CALC
        tick();
        w++;
      end
      checks++;
      assert ({out_valid, q, r, dz} === {1'b1, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0}) else begin
        errors++;
        bad = 1'b1;
        $error("FAIL rand_%0d observed=%0h/%0h expected=%0h/%0h a=%0h b=%0h: error",
               i, q, r, ra / 16'(rb), ra % 16'(rb), ra, rb);
      end
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
